keymatrix: RTL and testbench



---
 rtl/keymatrix.sv | 173 +++++++++++++++++
 tb/tb_keymatrix.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keymatrix.sv
// keymatrix: turns PS/2 set-2 key events into the 8x5 ZX Spectrum keyboard matrix.
//
// Each mapped PC key has its own held bit, so typematic repeats are idempotent
// and overlapping composite keys (which share Spectrum keys such as CS) release
// cleanly. The Spectrum matrix is the OR of every held PC key feeding a position.
//
// Ports:
//   clock  in   system clock, all state on posedge
//   reset  in   synchronous, active-low; clears held keys, keys=1F, clear=0
//   kstb   in   one-clock strobe qualifying make/code
//   make   in   0 = pressed, 1 = released
//   code   in   [7:0] set-2 scan code, prefixes stripped
//   addr   in   [7:0] CPU A15..A8; row n selected when addr[n]=0
//   keys   out  [4:0] column data D4..D0, active-low, registered
//   clear  out  one-clock pulse after an error code (00/FF) wiped the matrix

module keymatrix (
    input  logic       clock,
    input  logic       reset,
    input  logic       kstb,
    input  logic       make,
    input  logic [7:0] code,
    input  logic [7:0] addr,
    output logic [4:0] keys,
    output logic       clear
);

    // Held-bit layout: 0..39 are direct keys at row*5+col (CS slot holds L-shift,
    // SS slot holds L-ctrl); 40..48 are R-shift and the composite keys.
    localparam int unsigned NumHeld = 49;

    localparam logic [5:0] IdxRShift = 6'd40;
    localparam logic [5:0] IdxBksp   = 6'd41;
    localparam logic [5:0] IdxEsc    = 6'd42;
    localparam logic [5:0] IdxLeft   = 6'd43;
    localparam logic [5:0] IdxDown   = 6'd44;
    localparam logic [5:0] IdxUp     = 6'd45;
    localparam logic [5:0] IdxRight  = 6'd46;
    localparam logic [5:0] IdxComma  = 6'd47;
    localparam logic [5:0] IdxPeriod = 6'd48;

    logic [NumHeld-1:0] held_q, held_d;
    logic [39:0]        matrix;
    logic [4:0]         keys_q, keys_d;
    logic               clear_q, clear_d;
    logic [5:0]         idx;
    logic               hit;
    logic               err;

    // Scan code to held-bit index.
    always_comb begin
        hit = 1'b1;
        idx = 6'd0;
        case (code)
            // row0: CS Z X C V
            8'h12: idx = 6'd0;
            8'h1A: idx = 6'd1;
            8'h22: idx = 6'd2;
            8'h21: idx = 6'd3;
            8'h2A: idx = 6'd4;
            // row1: A S D F G
            8'h1C: idx = 6'd5;
            8'h1B: idx = 6'd6;
            8'h23: idx = 6'd7;
            8'h2B: idx = 6'd8;
            8'h34: idx = 6'd9;
            // row2: Q W E R T
            8'h15: idx = 6'd10;
            8'h1D: idx = 6'd11;
            8'h24: idx = 6'd12;
            8'h2D: idx = 6'd13;
            8'h2C: idx = 6'd14;
            // row3: 1 2 3 4 5
            8'h16: idx = 6'd15;
            8'h1E: idx = 6'd16;
            8'h26: idx = 6'd17;
            8'h25: idx = 6'd18;
            8'h2E: idx = 6'd19;
            // row4: 0 9 8 7 6
            8'h45: idx = 6'd20;
            8'h46: idx = 6'd21;
            8'h3E: idx = 6'd22;
            8'h3D: idx = 6'd23;
            8'h36: idx = 6'd24;
            // row5: P O I U Y
            8'h4D: idx = 6'd25;
            8'h44: idx = 6'd26;
            8'h43: idx = 6'd27;
            8'h3C: idx = 6'd28;
            8'h35: idx = 6'd29;
            // row6: Enter L K J H
            8'h5A: idx = 6'd30;
            8'h4B: idx = 6'd31;
            8'h42: idx = 6'd32;
            8'h3B: idx = 6'd33;
            8'h33: idx = 6'd34;
            // row7: Space SS M N B
            8'h29: idx = 6'd35;
            8'h14: idx = 6'd36;
            8'h3A: idx = 6'd37;
            8'h31: idx = 6'd38;
            8'h32: idx = 6'd39;
            // second CS source and composites
            8'h59: idx = IdxRShift;
            8'h66: idx = IdxBksp;
            8'h76: idx = IdxEsc;
            8'h6B: idx = IdxLeft;
            8'h72: idx = IdxDown;
            8'h75: idx = IdxUp;
            8'h74: idx = IdxRight;
            8'h41: idx = IdxComma;
            8'h49: idx = IdxPeriod;
            default: hit = 1'b0;
        endcase
    end

    assign err = (code == 8'h00) || (code == 8'hFF);

    always_comb begin
        held_d  = held_q;
        clear_d = 1'b0;
        if (kstb) begin
            if (err) begin
                held_d  = '0;
                clear_d = 1'b1;
            end else if (hit) begin
                held_d[idx] = ~make;
            end
        end
    end

    // Fold composite keys onto the Spectrum positions they press.
    always_comb begin
        matrix = held_q[39:0];
        matrix[0]  = held_q[0] | held_q[IdxRShift] | held_q[IdxBksp] | held_q[IdxEsc]
                   | held_q[IdxLeft] | held_q[IdxDown] | held_q[IdxUp] | held_q[IdxRight];
        matrix[19] = held_q[19] | held_q[IdxLeft];
        matrix[20] = held_q[20] | held_q[IdxBksp];
        matrix[22] = held_q[22] | held_q[IdxRight];
        matrix[23] = held_q[23] | held_q[IdxUp];
        matrix[24] = held_q[24] | held_q[IdxDown];
        matrix[35] = held_q[35] | held_q[IdxEsc];
        matrix[36] = held_q[36] | held_q[IdxComma] | held_q[IdxPeriod];
        matrix[37] = held_q[37] | held_q[IdxPeriod];
        matrix[38] = held_q[38] | held_q[IdxComma];
    end

    // Selected rows combine as a wired-AND of active-low column data.
    always_comb begin
        keys_d = 5'h1F;
        for (int n = 0; n < 8; n++) begin
            if (!addr[n]) begin
                keys_d = keys_d & ~matrix[n*5 +: 5];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            held_q  <= '0;
            keys_q  <= 5'h1F;
            clear_q <= 1'b0;
        end else begin
            held_q  <= held_d;
            keys_q  <= keys_d;
            clear_q <= clear_d;
        end
    end

    assign keys  = keys_q;
    assign clear = clear_q;

endmodule

// File: tb/tb_keymatrix.sv
module tb_keymatrix;

    logic       clock;
    logic       reset;
    logic       kstb;
    logic       make;
    logic [7:0] code;
    logic [7:0] addr;
    logic [4:0] keys;
    logic       clear;

    int vectors;
    int miscompares;

    keymatrix dut (
        .clock (clock),
        .reset (reset),
        .kstb  (kstb),
        .make  (make),
        .code  (code),
        .addr  (addr),
        .keys  (keys),
        .clear (clear)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input logic m, input logic [7:0] c);
        kstb = 1'b1;
        make = m;
        code = c;
        tick();
        kstb = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        addr  = 8'h00;
        tick();
        tick();
        vectors++;
        if (keys !== 5'h1F) begin
            miscompares++;
            $display("FAIL reset_keys: got %h want 1F", keys);
        end
        vectors++;
        if (clear !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_clear: got %b want 0", clear);
        end
        reset = 1'b1;
        tick();
        vectors++;
        if (keys !== 5'h1F) begin
            miscompares++;
            $display("FAIL post_reset_keys: got %h want 1F", keys);
        end
    endtask

    task automatic test_direct();
        strobe(1'b0, 8'h1C);
        addr = 8'hFD;
        tick();
        vectors++;
        if (keys !== 5'h1E) begin
            miscompares++;
            $display("FAIL direct_a_row1: got %h want 1E", keys);
        end
        addr = 8'hFE;
        tick();
        vectors++;
        if (keys !== 5'h1F) begin
            miscompares++;
            $display("FAIL direct_a_row0: got %h want 1F", keys);
        end
        addr = 8'hFF;
        tick();
        vectors++;
        if (keys !== 5'h1F) begin
            miscompares++;
            $display("FAIL addr_ff: got %h want 1F", keys);
        end
        strobe(1'b1, 8'h1C);
        addr = 8'hFD;
        tick();
        vectors++;
        if (keys !== 5'h1F) begin
            miscompares++;
            $display("FAIL direct_a_break: got %h want 1F", keys);
        end
    endtask

    task automatic test_unmapped();
        strobe(1'b0, 8'h0D);
        addr = 8'h00;
        tick();
        vectors++;
        if (keys !== 5'h1F) begin
            miscompares++;
            $display("FAIL unmapped: got %h want 1F", keys);
        end
    endtask

    task automatic test_composite();
        strobe(1'b0, 8'h66);
        addr = 8'hFE;
        tick();
        vectors++;
        if (keys !== 5'h1E) begin
            miscompares++;
            $display("FAIL bksp_cs: got %h want 1E", keys);
        end
        addr = 8'hEF;
        tick();
        vectors++;
        if (keys !== 5'h1E) begin
            miscompares++;
            $display("FAIL bksp_zero: got %h want 1E", keys);
        end
        strobe(1'b0, 8'h12);
        strobe(1'b1, 8'h66);
        addr = 8'hFE;
        tick();
        vectors++;
        if (keys !== 5'h1E) begin
            miscompares++;
            $display("FAIL shift_keeps_cs: got %h want 1E", keys);
        end
        addr = 8'hEF;
        tick();
        vectors++;
        if (keys !== 5'h1F) begin
            miscompares++;
            $display("FAIL bksp_zero_released: got %h want 1F", keys);
        end
        strobe(1'b1, 8'h12);
        addr = 8'hFE;
        tick();
        vectors++;
        if (keys !== 5'h1F) begin
            miscompares++;
            $display("FAIL shift_released: got %h want 1F", keys);
        end
    endtask

    task automatic test_repeat();
        // Back-to-back makes on consecutive clocks.
        strobe(1'b0, 8'h3A);
        strobe(1'b0, 8'h3A);
        strobe(1'b0, 8'h3A);
        addr = 8'h7F;
        tick();
        vectors++;
        if (keys !== 5'h1B) begin
            miscompares++;
            $display("FAIL repeat_make: got %h want 1B", keys);
        end
        strobe(1'b1, 8'h3A);
        tick();
        vectors++;
        if (keys !== 5'h1F) begin
            miscompares++;
            $display("FAIL repeat_break: got %h want 1F", keys);
        end
    endtask

    task automatic test_back_to_back();
        strobe(1'b0, 8'h1A);
        strobe(1'b0, 8'h15);
        addr = 8'hFA;
        tick();
        vectors++;
        if (keys !== 5'h1C) begin
            miscompares++;
            $display("FAIL multirow_zq: got %h want 1C", keys);
        end
    endtask

    task automatic test_error();
        strobe(1'b0, 8'h14);
        strobe(1'b0, 8'h41);
        strobe(1'b0, 8'h29);
        addr = 8'h7F;
        tick();
        // Space, SS, N held
        vectors++;
        if (keys !== 5'h14) begin
            miscompares++;
            $display("FAIL row7_before_clear: got %h want 14", keys);
        end
        strobe(1'b1, 8'hFF);
        vectors++;
        if (clear !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_pulse: got %b want 1", clear);
        end
        addr = 8'h00;
        tick();
        vectors++;
        if (clear !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_width: got %b want 0", clear);
        end
        tick();
        vectors++;
        if (keys !== 5'h1F) begin
            miscompares++;
            $display("FAIL all_rows_after_clear: got %h want 1F", keys);
        end
        strobe(1'b1, 8'h41);
        tick();
        vectors++;
        if (keys !== 5'h1F) begin
            miscompares++;
            $display("FAIL break_after_clear: got %h want 1F", keys);
        end
        strobe(1'b0, 8'h1C);
        strobe(1'b0, 8'h00);
        vectors++;
        if (clear !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_code00: got %b want 1", clear);
        end
        addr = 8'hFD;
        tick();
        vectors++;
        if (keys !== 5'h1F) begin
            miscompares++;
            $display("FAIL row1_after_code00: got %h want 1F", keys);
        end
    endtask

    task automatic test_reset_mid();
        strobe(1'b0, 8'h5A);
        addr = 8'hBF;
        tick();
        vectors++;
        if (keys !== 5'h1E) begin
            miscompares++;
            $display("FAIL enter_held: got %h want 1E", keys);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (keys !== 5'h1F) begin
            miscompares++;
            $display("FAIL keys_in_reset: got %h want 1F", keys);
        end
        reset = 1'b1;
        tick();
        vectors++;
        if (keys !== 5'h1F) begin
            miscompares++;
            $display("FAIL enter_after_reset: got %h want 1F", keys);
        end
        reset = 1'b0;
        kstb  = 1'b1;
        make  = 1'b0;
        code  = 8'h5A;
        tick();
        reset = 1'b1;
        kstb  = 1'b0;
        tick();
        tick();
        vectors++;
        if (keys !== 5'h1F) begin
            miscompares++;
            $display("FAIL strobe_in_reset: got %h want 1F", keys);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b0;
        kstb  = 1'b0;
        make  = 1'b1;
        code  = 8'h00;
        addr  = 8'hFF;
        test_reset();
        test_direct();
        test_unmapped();
        test_composite();
        test_repeat();
        test_back_to_back();
        test_error();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
